// File: rtl/demux_burst_sched.sv
// Round-robin burst scheduler: one valid/ready stream into NOUT lanes via a one-word register.
// Optional lane skipping with en_mask when DEMUX_SKIP_EN is defined.
module demux_burst_sched #(
    parameter  int DW    = 8,
    parameter  int NOUT  = 4,
    parameter  int BURST = 4,
    localparam int SW    = $clog2(NOUT),
    localparam int CW    = $clog2(BURST + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic [NOUT-1:0] out_valid,
    input  logic [NOUT-1:0] out_ready,
    output logic [DW-1:0]   out_data,
    input  logic [NOUT-1:0] en_mask,
    output logic [SW-1:0]   sel,
    output logic [CW-1:0]   burst_cnt,
    output logic            busy
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_data;
    logic [SW-1:0]   r_dest;
    logic [SW-1:0]   r_sel;
    logic [CW-1:0]   r_cnt;

    logic            w_full;
    logic            w_in_hs;
    logic            w_lane_hs;
    logic            w_burst_end;
    logic            w_hop;
    logic            w_lane_ok;
    logic [NOUT-1:0] w_mask;
    logic [SW-1:0]   w_next_sel;
    logic            w_found;

`ifdef DEMUX_SKIP_EN
    assign w_mask    = en_mask;
    assign w_lane_ok = en_mask[r_sel];
    assign w_hop     = ~clr & ~en_mask[r_sel] & (|en_mask);
`else
    logic w_unused_mask;
    assign w_unused_mask = ^en_mask;
    assign w_mask    = '1;
    assign w_lane_ok = 1'b1;
    assign w_hop     = 1'b0;
`endif

    assign w_full      = (r_state == S_FULL);
    assign w_lane_hs   = w_full & out_ready[r_dest];
    assign in_ready    = ~clr & (~w_full | out_ready[r_dest]) & w_lane_ok;
    assign w_in_hs     = in_valid & in_ready;
    assign w_burst_end = (r_cnt == CW'(BURST - 1));

    // First enabled lane after r_sel; stays on r_sel if no other lane is enabled.
    always_comb begin
        w_next_sel = r_sel;
        w_found    = 1'b0;
        for (int k = 1; k < NOUT; k++) begin
            if (!w_found && w_mask[(int'(r_sel) + k) % NOUT]) begin
                w_next_sel = SW'((int'(r_sel) + k) % NOUT);
                w_found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: if (w_in_hs) w_state_nxt = S_FULL;
                S_FULL:  if (w_lane_hs && !w_in_hs) w_state_nxt = S_EMPTY;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = '0;
        busy      = 1'b0;
        if (r_state == S_FULL) begin
            out_valid = NOUT'(1) << r_dest;
            busy      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_dest <= '0;
        end else if (w_in_hs) begin
            r_data <= in_data;
            r_dest <= r_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_sel <= '0;
            r_cnt <= '0;
        end else if (w_in_hs) begin
            if (w_burst_end) begin
                r_sel <= w_next_sel;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (w_hop) begin
            r_sel <= w_next_sel;
            r_cnt <= '0;
        end
    end

    assign out_data  = r_data;
    assign sel       = r_sel;
    assign burst_cnt = r_cnt;

endmodule

// File: tb/tb_demux_burst_sched.sv
// Directed bench for demux_burst_sched (NOUT=4, BURST=4).
// Inputs change at the falling edge; outputs are sampled there too.
module tb_demux_burst_sched;

    localparam int DW    = 8;
    localparam int NOUT  = 4;
    localparam int BURST = 4;
    localparam int SW    = $clog2(NOUT);
    localparam int CW    = $clog2(BURST + 1);

    logic            clk;
    logic            rst_n;
    logic            clr;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [NOUT-1:0] out_valid;
    logic [NOUT-1:0] out_ready;
    logic [DW-1:0]   out_data;
    logic [NOUT-1:0] en_mask;
    logic [SW-1:0]   sel;
    logic [CW-1:0]   burst_cnt;
    logic            busy;

    int n_checks;
    int n_fail;

    demux_burst_sched #(
        .DW(DW),
        .NOUT(NOUT),
        .BURST(BURST)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .en_mask(en_mask),
        .sel(sel),
        .burst_cnt(burst_cnt),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '0;
`ifdef DEMUX_SKIP_EN
        en_mask   = 4'b1010;
`else
        en_mask   = 4'hF;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_cnt", 32'(burst_cnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

`ifdef DEMUX_SKIP_EN
        rst_n     = 1'b1;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_data   = 8'h40;
        #1;
        chk("skip_rdy0", 32'(in_ready), 32'h0);
        tick();
        chk("skip_hop_sel", 32'(sel), 32'h1);
        chk("skip_hop_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 12; i++) begin
            in_data = 8'(8'h40 + i);
            #1;
            chk("skip_rdy", 32'(in_ready), 32'h1);
            tick();
            chk("skip_lane", 32'(out_valid),
                (i / 4 == 1) ? 32'h8 : 32'h2);
            chk("skip_data", 32'(out_data), 32'(8'h40 + i));
        end
        chk("skip_sel3", 32'(sel), 32'h3);
        tick();
        tick();
        chk("skip_cnt2", 32'(burst_cnt), 32'h2);
        en_mask = 4'b0010;
        #1;
        chk("skip_rdy_off", 32'(in_ready), 32'h0);
        tick();
        chk("skip_sel1", 32'(sel), 32'h1);
        chk("skip_cnt0", 32'(burst_cnt), 32'h0);
`else
        // Reset release into full-rate streaming.
        rst_n     = 1'b1;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i);
            #1;
            chk("str_rdy", 32'(in_ready), 32'h1);
            chk("str_sel", 32'(sel), 32'(i / 4));
            chk("str_cnt", 32'(burst_cnt), 32'(i % 4));
            if (i > 0) begin
                chk("str_valid", 32'(out_valid), 32'(1 << ((i - 1) / 4)));
                chk("str_data", 32'(out_data), 32'(i - 1));
            end else begin
                chk("str_first", 32'(out_valid), 32'h0);
            end
            tick();
        end
        chk("str_last_v", 32'(out_valid), 32'h8);
        chk("str_last_d", 32'(out_data), 32'h0F);
        chk("str_wrap", 32'(sel), 32'h0);

        // Stall lane 1 while 0x04 is held.
        clr = 1'b1;
        #1;
        chk("clr_rdy", 32'(in_ready), 32'h0);
        tick();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(i);
            tick();
        end
        out_ready = 4'b1101;
        in_data   = 8'h05;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stl_rdy", 32'(in_ready), 32'h0);
            chk("stl_data", 32'(out_data), 32'h04);
            chk("stl_valid", 32'(out_valid), 32'h2);
            chk("stl_cnt", 32'(burst_cnt), 32'h1);
            tick();
        end
        out_ready = 4'hF;
        for (int i = 5; i < 8; i++) begin
            in_data = 8'(i);
            #1;
            chk("rel_rdy", 32'(in_ready), 32'h1);
            tick();
            chk("rel_data", 32'(out_data), 32'(i));
            chk("rel_valid", 32'(out_valid), 32'h2);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_busy", 32'(busy), 32'h0);
        chk("drain_sel", 32'(sel), 32'h2);

        // Simultaneous drain and fill across a burst boundary.
        clr = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(8'h20 + i);
            tick();
            chk("df_busy", 32'(busy), 32'h1);
            chk("df_valid", 32'(out_valid), (i < 4) ? 32'h1 : 32'h2);
            chk("df_data", 32'(out_data), 32'(8'h20 + i));
        end

        // clr mid-burst with held word 0x0A on lane 2.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_data = (i == 9) ? 8'h0A : 8'(i);
            tick();
        end
        chk("mid_sel", 32'(sel), 32'h2);
        chk("mid_cnt", 32'(burst_cnt), 32'h2);
        chk("mid_data", 32'(out_data), 32'h0A);
        chk("mid_valid", 32'(out_valid), 32'h4);
        clr     = 1'b1;
        in_data = 8'h55;
        #1;
        chk("mclr_rdy", 32'(in_ready), 32'h0);
        tick();
        clr = 1'b0;
        chk("mclr_valid", 32'(out_valid), 32'h0);
        chk("mclr_sel", 32'(sel), 32'h0);
        chk("mclr_cnt", 32'(burst_cnt), 32'h0);
        in_data = 8'h33;
        tick();
        chk("post_valid", 32'(out_valid), 32'h1);
        chk("post_data", 32'(out_data), 32'h33);

        // Asynchronous reset between edges while FULL.
        in_valid  = 1'b0;
        out_ready = '0;
        tick();
        chk("ar_busy_pre", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'h0);
        chk("ar_data", 32'(out_data), 32'h0);
        chk("ar_sel", 32'(sel), 32'h0);
        chk("ar_cnt", 32'(burst_cnt), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_rdy", 32'(in_ready), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_burst_sched.md
# demux_burst_sched

Round-robin burst scheduler that feeds one valid/ready input stream into NOUT output lanes through a registered demux stage. It accepts BURST consecutive words for the current lane, then rotates to the next lane. It sits in front of the demux datapath and sequences its select line, so downstream consumers each receive whole bursts. A one-word output register with back-pressure pass-through decouples the input from the lanes.

## Interface
- DW, 8: data width in bits.
- NOUT, 4: number of output lanes; must be ≥2.
- BURST, 4: words per lane before rotation; must be ≥1.
- SW = $clog2(NOUT), CW = $clog2(BURST+1): derived localparams.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear: drops held word, sel=0, cnt=0.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  DW  input word.
- out_valid  out  NOUT  one-hot; bit i means the held word targets lane i.
- out_ready  in  NOUT  per-lane ready.
- out_data  out  DW  held word, shared by all lanes.
- en_mask  in  NOUT  lane enable mask; used only with DEMUX_SKIP_EN.
- sel  out  SW  lane that receives the next accepted word.
- burst_cnt  out  CW  words accepted in the current burst (0..BURST-1).
- busy  out  1  output register holds a word.

## Operation
- Two-state FSM on the output register.
  - EMPTY to FULL on input handshake.
  - FULL to EMPTY on lane handshake without a new input word.
  - FULL stays FULL on lane handshake plus input handshake in the same cycle.
- Input handshake: in_valid & in_ready.
- in_ready = ~clr & (EMPTY | out_ready[dest]), where dest is the lane of the held word. Without SKIP_EN there is no further term; with SKIP_EN see Configuration.
- On input handshake:
  - out_data <= in_data; dest <= sel.
  - If burst_cnt == BURST-1: burst_cnt <= 0 and sel <= next lane; otherwise burst_cnt++.
  - Next lane is (sel+1) mod NOUT, wrapping NOUT-1 to 0.
- out_valid = FULL ? (1 << dest) : 0. out_data is stable while out_valid is set and the lane has not handshaken.
- Lane handshake: out_valid[dest] & out_ready[dest]. Ready bits on other lanes are ignored.
- clr has priority over every other event:
  - Next cycle: EMPTY, sel=0, burst_cnt=0.
  - Any concurrent input or lane handshake is void, because in_ready=0 while clr is high.
- Reset values: out_valid=0, out_data=0, sel=0, burst_cnt=0, busy=0. in_ready=1 once rst_n is released and clr is low.
- Reset asserted mid-burst: the held word is lost and the rotation restarts at lane 0.

## Timing
- Latency: a word accepted at edge t is presented at out_valid/out_data from edge t, visible in cycle t+1.
- Throughput: 1 word/cycle while the destination lane stays ready.
- Back-pressure:
  - With a held word, out_ready[dest]=0 forces in_ready=0 combinationally.
  - No combinational path from in_valid to any output.
- sel and burst_cnt update only on input-handshake edges, on clr, or on a SKIP_EN hop.
- A burst may straddle stalls; rotation depends only on the accepted-word count.

## Configuration
- DEMUX_SKIP_EN defined: en_mask gates scheduling.
  - in_ready additionally requires en_mask[sel].
  - If en_mask[sel]==0 (and clr is low): in_ready=0 that cycle. Next edge sets sel <= first enabled lane after sel (cyclic) and burst_cnt <= 0, abandoning any partial burst.
  - Rotation at burst end also skips to the next enabled lane. If sel is the only enabled lane, sel is unchanged.
  - en_mask == 0: in_ready=0 and sel is held. The held word still drains normally.
- DEMUX_SKIP_EN undefined: en_mask is ignored and rotation is strict 0,1,…,NOUT-1,0.

## Test plan
- Reset then streaming: release rst_n with all out_ready=1 and in_valid=1, 16 words 0x00..0x0F (NOUT=4, BURST=4).
  - Words 0x00-0x03 appear on lane 0, 0x04-0x07 on lane 1, and so on; 0x0C-0x0F on lane 3.
  - One word per cycle, first out_valid one cycle after the first accept; sel wraps to 0.
- Stall: hold out_ready[1]=0 for 5 cycles while word 0x04 is held.
  - in_ready=0, out_data stays 0x04, out_valid=4'b0010, burst_cnt=1.
  - After release, 0x05-0x07 follow on lane 1 back-to-back.
- Simultaneous drain and fill: FULL with out_ready[dest]=1 and in_valid=1 for 8 cycles.
  - busy stays 1 and no bubbles occur.
  - out_valid rotates 0001 to 0010 at the burst boundary.
- clr mid-burst: assert clr with sel=2, burst_cnt=2, held word 0x0A, and in_valid=1.
  - in_ready=0; next cycle out_valid=0, sel=0, burst_cnt=0.
  - Next word goes to lane 0.
- Async reset mid-transfer: pull rst_n low between edges while FULL.
  - All outputs return to reset values immediately, without waiting for a clock edge.
- SKIP_EN (compiled with DEMUX_SKIP_EN): en_mask=4'b1010, stream 12 words.
  - First cycle in_ready=0 and sel hops 0→1.
  - Bursts then go to lanes 1,3,1; lanes 0 and 2 never see out_valid.
  - Clearing en_mask[3] while sel=3 with burst_cnt=2 hops to lane 1 with burst_cnt=0.
